cpu_control_fsm: RTL and testbench

Multicycle control sequencer for the ARM-subset processor datapath. It fetches an instruction through a valid-handshake and latches it into an internal instruction register. It evaluates the condition field against a stored NZCV flag register, then drives the datapath control inputs state by state. Data-memory accesses use a req/ready handshake with timeout. It sits between instruction/data memory and the datapath; the datapath PC advances only on PCWrite.

---
 rtl/cpu_control_fsm_if.sv | 37 +++
 rtl/cpu_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Control-sequencer bus: fetch handshake, data-memory handshake, datapath controls, status.
// master = sequencer side, slave = memory/datapath side.
interface cpu_control_fsm_if;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [3:0]  ALUFlags;
    logic        mem_ready;

    logic        instr_req;
    logic        mem_req;
    logic        PCWrite;
    logic        PCSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUSrc;
    logic [2:0]  ALUControl;
    logic        MemWrite;
    logic        MemtoReg;
    logic        BL;
    logic        ShiftEn;
    logic [3:0]  flags_q;
    logic        illegal;
    logic        mem_fault;

    modport master (
        input  Instr, instr_valid, ALUFlags, mem_ready,
        output instr_req, mem_req, PCWrite, PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc,
               ALUControl, MemWrite, MemtoReg, BL, ShiftEn, flags_q, illegal, mem_fault
    );

    modport slave (
        output Instr, instr_valid, ALUFlags, mem_ready,
        input  instr_req, mem_req, PCWrite, PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc,
               ALUControl, MemWrite, MemtoReg, BL, ShiftEn, flags_q, illegal, mem_fault
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multicycle ARM-subset control sequencer: fetch, decode/condition check, execute, memory, branch.
// Latency 3 cycles per instruction (+ memory wait); stalls in FETCH/MEM until valid/ready or timeout.
module cpu_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic              clk,
    input logic              reset,
    cpu_control_fsm_if.master bus
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [3:0] CMD_CMP = 4'b1010;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC_DP, S_MEM, S_BRANCH, S_ADVANCE
    } state_t;

    state_t        state;
    logic [31:0]   ir;
    logic [3:0]    flags;
    logic [CW-1:0] cnt;

    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic       imm_bit, s_bit;
    logic       cond_pass, dp_ok, mem_timeout_hit;
    logic [2:0] dp_alu;
    logic       unused_ir;

    assign cond    = ir[31:28];
    assign op      = ir[27:26];
    assign imm_bit = ir[25];
    assign cmd     = ir[24:21];
    assign s_bit   = ir[20];
    assign unused_ir = ^{ir[19:12], ir[3:0]};

    always_comb begin
        unique case (cond)
            4'b0000: cond_pass = flags[2];
            4'b0001: cond_pass = !flags[2];
            4'b0010: cond_pass = flags[1];
            4'b0011: cond_pass = !flags[1];
            4'b0100: cond_pass = flags[3];
            4'b0101: cond_pass = !flags[3];
            4'b0110: cond_pass = flags[0];
            4'b0111: cond_pass = !flags[0];
            4'b1000: cond_pass = flags[1] && !flags[2];
            4'b1001: cond_pass = !flags[1] || flags[2];
            4'b1010: cond_pass = (flags[3] == flags[0]);
            4'b1011: cond_pass = (flags[3] != flags[0]);
            4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dp_ok  = 1'b1;
        dp_alu = 3'b000;
        case (cmd)
            4'b0100: dp_alu = 3'b000;
            4'b0010: dp_alu = 3'b001;
            4'b1010: dp_alu = 3'b001;
            4'b0000: dp_alu = 3'b010;
            4'b1100: dp_alu = 3'b011;
            4'b0001: dp_alu = 3'b100;
            4'b1101: dp_alu = 3'b101;
            default: dp_ok  = 1'b0;
        endcase
    end

    assign mem_timeout_hit = (state == S_MEM) && !bus.mem_ready && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= '0;
            flags <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        ir    <= bus.Instr;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!cond_pass)                state <= S_ADVANCE;
                    else if (op == 2'b00 && dp_ok) state <= S_EXEC_DP;
                    else if (op == 2'b01)          state <= S_MEM;
                    else if (op == 2'b10)          state <= S_BRANCH;
                    else                           state <= S_ADVANCE;
                end
                S_EXEC_DP: begin
                    if (s_bit || cmd == CMD_CMP) flags <= bus.ALUFlags;
                    state <= S_FETCH;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        cnt   <= '0;
                        state <= S_FETCH;
                    end else if (mem_timeout_hit) begin
                        cnt   <= '0;
                        state <= S_ADVANCE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode purely from registered state/IR; only MEM completion is qualified by mem_ready.
    always_comb begin
        bus.instr_req  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.PCSrc      = 1'b0;
        bus.RegSrc     = 2'b00;
        bus.RegWrite   = 1'b0;
        bus.ImmSrc     = 2'b00;
        bus.ALUSrc     = 2'b00;
        bus.ALUControl = 3'b000;
        bus.MemWrite   = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.BL         = 1'b0;
        bus.ShiftEn    = 1'b0;
        bus.illegal    = 1'b0;
        bus.mem_fault  = 1'b0;
        unique case (state)
            S_FETCH:  bus.instr_req = 1'b1;
            S_DECODE: bus.illegal = cond_pass && ((op == 2'b11) || (op == 2'b00 && !dp_ok));
            S_EXEC_DP: begin
                bus.ALUSrc     = {1'b0, imm_bit};
                bus.ALUControl = dp_alu;
                bus.RegWrite   = (cmd != CMD_CMP);
                bus.PCWrite    = 1'b1;
                bus.ShiftEn    = !imm_bit && (ir[11:4] != 8'h00);
            end
            S_MEM: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrc    = 2'b01;
                bus.ImmSrc    = 2'b01;
                bus.MemWrite  = !s_bit;
                bus.RegSrc    = {!s_bit, 1'b0};
                bus.PCWrite   = bus.mem_ready;
                bus.RegWrite  = bus.mem_ready && s_bit;
                bus.MemtoReg  = bus.mem_ready && s_bit;
                bus.mem_fault = mem_timeout_hit;
            end
            S_BRANCH: begin
                bus.RegSrc   = 2'b01;
                bus.ImmSrc   = 2'b10;
                bus.ALUSrc   = 2'b01;
                bus.PCSrc    = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.BL       = ir[24];
                bus.RegWrite = ir[24];
            end
            default: bus.PCWrite = 1'b1;
        endcase
    end

    assign bus.flags_q = flags;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Transaction-level checker for cpu_control_fsm: each instruction expands into its expected per-cycle control trace.
module tb_cpu_control_fsm;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] model_flags = 4'b0000;

    always #5 clk = ~clk;

    cpu_control_fsm_if bus ();
    cpu_control_fsm #(.MEM_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic       instr_req, mem_req, pc_write, pc_src;
        logic [1:0] reg_src;
        logic       reg_write;
        logic [1:0] imm_src, alu_src;
        logic [2:0] alu_ctl;
        logic       mem_write, memto_reg, bl, shift_en, illegal, mem_fault;
    } ctl_t;

    function automatic ctl_t observed();
        ctl_t o;
        o.instr_req = bus.instr_req;  o.mem_req   = bus.mem_req;
        o.pc_write  = bus.PCWrite;    o.pc_src    = bus.PCSrc;
        o.reg_src   = bus.RegSrc;     o.reg_write = bus.RegWrite;
        o.imm_src   = bus.ImmSrc;     o.alu_src   = bus.ALUSrc;
        o.alu_ctl   = bus.ALUControl; o.mem_write = bus.MemWrite;
        o.memto_reg = bus.MemtoReg;   o.bl        = bus.BL;
        o.shift_en  = bus.ShiftEn;    o.illegal   = bus.illegal;
        o.mem_fault = bus.mem_fault;
        return o;
    endfunction

    // Even codes test a predicate, odd codes its negation; 1111 is the negation of AL.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    // Returns 3'b111 for commands outside the supported data-processing set.
    function automatic logic [2:0] dp_op(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'd0;
            4'b0010, 4'b1010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            4'b0001: return 3'd4;
            4'b1101: return 3'd5;
            default: return 3'b111;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [3:0] fl,
                       input logic rdy, input ctl_t exp, input string tag, input logic rs = 1'b0);
        ctl_t obs;
        @(negedge clk);
        bus.instr_valid = v;
        bus.Instr       = ins;
        bus.ALUFlags    = fl;
        bus.mem_ready   = rdy;
        reset           = rs;
        #1;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ctl observed=%h expected=%h", tag, obs, exp);
        end
        checks++;
        assert (bus.flags_q === model_flags) else begin
            failures++;
            $error("FAIL %s flags_q observed=%b expected=%b", tag, bus.flags_q, model_flags);
        end
    endtask

    function automatic ctl_t fetch_vec();
        ctl_t e = '0;
        e.instr_req = 1'b1;
        return e;
    endfunction

    task automatic run(input logic [31:0] ins, input int stall, input int wait_n,
                       input logic [3:0] dpf, input string tag);
        ctl_t e;
        logic pass, ill, done, l_bit;
        logic [1:0] op;
        logic [2:0] alu;
        for (int i = 0; i < stall; i++)
            cyc(1'b0, $urandom, 4'($urandom), 1'($urandom), fetch_vec(), {tag, ":stall"});
        cyc(1'b1, ins, 4'($urandom), 1'($urandom), fetch_vec(), {tag, ":fetch"});

        op   = ins[27:26];
        alu  = dp_op(ins[24:21]);
        pass = cond_ok(ins[31:28], model_flags);
        ill  = pass && (op == 2'b11 || (op == 2'b00 && alu == 3'b111));
        e = '0;
        e.illegal = ill;
        cyc(1'($urandom), $urandom, 4'($urandom), 1'($urandom), e, {tag, ":decode"});

        done = 1'b0;
        if (pass && !ill) begin
            e = '0;
            if (op == 2'b00) begin
                e.alu_src   = {1'b0, ins[25]};
                e.alu_ctl   = alu;
                e.reg_write = (ins[24:21] != 4'b1010);
                e.pc_write  = 1'b1;
                e.shift_en  = !ins[25] && (ins[11:4] != 8'h00);
                cyc(1'($urandom), $urandom, dpf, 1'($urandom), e, {tag, ":exec"});
                if (ins[20] || ins[24:21] == 4'b1010) model_flags = dpf;
                done = 1'b1;
            end else if (op == 2'b01) begin
                l_bit = ins[20];
                for (int k = 0; k < T && !done; k++) begin
                    e = '0;
                    e.mem_req   = 1'b1;
                    e.alu_src   = 2'b01;
                    e.imm_src   = 2'b01;
                    e.mem_write = !l_bit;
                    e.reg_src   = {!l_bit, 1'b0};
                    if (k == wait_n) begin
                        e.pc_write  = 1'b1;
                        e.reg_write = l_bit;
                        e.memto_reg = l_bit;
                        done = 1'b1;
                    end else if (k == T - 1) begin
                        e.mem_fault = 1'b1;
                    end
                    cyc(1'($urandom), $urandom, 4'($urandom), (k == wait_n), e, {tag, ":mem"});
                end
            end else begin
                e.reg_src   = 2'b01;
                e.imm_src   = 2'b10;
                e.alu_src   = 2'b01;
                e.pc_src    = 1'b1;
                e.pc_write  = 1'b1;
                e.bl        = ins[24];
                e.reg_write = ins[24];
                cyc(1'($urandom), $urandom, 4'($urandom), 1'($urandom), e, {tag, ":branch"});
                done = 1'b1;
            end
        end
        if (!done) begin
            e = '0;
            e.pc_write = 1'b1;
            cyc(1'($urandom), $urandom, 4'($urandom), 1'($urandom), e, {tag, ":advance"});
        end
    endtask

    initial begin
        ctl_t e;
        logic [31:0] ins;
        logic [3:0]  cmds [8];
        int cls;
        cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b0111};
        bus.instr_valid = 1'b0;
        bus.Instr       = '0;
        bus.ALUFlags    = '0;
        bus.mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, fetch_vec(), "reset", 1'b1);

        run(32'hE0811002, 0, 0, 4'b1111, "add");
        run(32'hE3520005, 1, 0, 4'b0100, "cmp_z");
        run(32'h0A000002, 0, 0, 4'b0000, "beq_taken");
        run(32'hE3520005, 0, 0, 4'b0000, "cmp_nz");
        run(32'h0A000002, 0, 0, 4'b0000, "beq_skip");
        run(32'hE5921004, 0, 3, 4'b0000, "ldr_wait3");
        run(32'hE5821004, 0, 0, 4'b0000, "str_now");
        run(32'hEB000010, 0, 0, 4'b0000, "bl");
        run(32'hE5921004, 0, T + 4, 4'b0000, "ldr_timeout");
        run(32'hE1A00102, 0, 0, 4'b0000, "mov_shift");
        run(32'hE3520005, 0, 0, 4'b1010, "cmp_set");

        cyc(1'b1, 32'hE5921004, 4'h0, 1'b0, fetch_vec(), "abort:fetch");
        cyc(1'b0, 32'h0, 4'h0, 1'b0, '0, "abort:decode");
        e = '0;
        e.mem_req = 1'b1; e.alu_src = 2'b01; e.imm_src = 2'b01;
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'h0, 4'hF, 1'b0, e, "abort:mem");
        cyc(1'b0, 32'h0, 4'hF, 1'b0, e, "abort:mem5", 1'b1);
        model_flags = 4'b0000;
        cyc(1'b0, 32'h0, 4'hF, 1'b1, fetch_vec(), "abort:after");

        run(32'hEC000000, 0, 0, 4'b0000, "illegal_op");
        run(32'hE1E00000, 0, 0, 4'b0000, "illegal_cmd");
        run(32'hFC000000, 0, 0, 4'b0000, "never_cond");

        for (int n = 0; n < 120; n++) begin
            cls = int'($urandom_range(0, 4));
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
            case (cls)
                0, 1: begin
                    ins[27:26] = 2'b00;
                    ins[24:21] = cmds[$urandom_range(0, 7)];
                end
                2: ins[27:26] = 2'b01;
                3: ins[27:26] = 2'b10;
                default: ins[27:26] = 2'b11;
            endcase
            run(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, T + 2)),
                4'($urandom), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
